pwm_arbiter: RTL and testbench
==============================

# pwm_arbiter

Shares one `pwm` generator between NREQ requesters. Each requester presents its own period/duty/burst configuration and a request line. The arbiter grants one requester at a time, drives the shared generator's configuration and active-high reset, and holds the grant for a fixed number of PWM periods. It counts those periods internally and sits directly upstream of the `pwm` instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- HOLD_PERIODS, 4, PWM periods granted per win (1..255)
- LOAD_CYCLES, 2, cycles `pwm_rst` is held high before each run (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  request per requester, level-sensitive
- cfg_period  in  NREQ*16  per-requester period in clocks, slice i = [16i+15:16i]
- cfg_duty  in  NREQ*8  per-requester duty in percent, slice i = [8i+7:8i]
- cfg_mode  in  NREQ  per-requester burst-mode enable
- cfg_type  in  NREQ  per-requester burst type (1 = 32-div, 0 = 16-div)
- grant  out  NREQ  one-hot grant, 0 when no owner
- period  out  16  latched period to `pwm`
- dutyCycle  out  8  latched, clamped duty to `pwm`
- modeBurst  out  1  latched burst mode to `pwm`
- typeBurst  out  1  latched burst type to `pwm`
- pwm_rst  out  1  active-high reset to `pwm`
- busy  out  1  high in LOAD or RUN
- done  out  1  one-cycle pulse on normal completion
- abort  out  1  one-cycle pulse when owner drops `req` early

## Operation
- States (encodings in package): IDLE, ARB, LOAD, RUN, RELEASE.
- Reset values (`rst`=0, async):
  - state = IDLE; `grant` = 0; `period` = 0; `dutyCycle` = 0; `modeBurst` = 0; `typeBurst` = 0.
  - `pwm_rst` = 1; `busy` = 0; `done` = 0; `abort` = 0.
  - RR pointer = 0; all counters = 0.
- IDLE: `pwm_rst` = 1. Any `req` bit set → ARB.
- ARB:
  - Winner = first set `req` bit at or after the RR pointer, wrapping at NREQ.
  - Register `grant` one-hot and latch the winner's config.
  - Clamp rules: period < 2 → 2; duty > 100 → 100.
  - Next state LOAD. If `req` is all zero at ARB, go to IDLE with no grant.
- LOAD: `pwm_rst` = 1 for exactly LOAD_CYCLES cycles, then RUN.
- RUN:
  - `pwm_rst` = 0.
  - 16-bit cycle counter counts 0..period-1. On wrap, the 8-bit period counter increments.
  - When the period counter reaches HOLD_PERIODS at a wrap → RELEASE with `done`.
- RELEASE (1 cycle):
  - `pwm_rst` = 1 and `grant` = 0.
  - Pulse `done` or `abort`.
  - RR pointer = (winner+1) mod NREQ.
  - Next state ARB if any `req` is set, else IDLE.
- Early drop: owner's `req` = 0 in LOAD or RUN → RELEASE next cycle with `abort`; `done` is not pulsed. Other requesters' `req` changes never affect the current owner.
- Config inputs are sampled only in ARB. Changes during LOAD/RUN are ignored.
- Width rules:
  - Counters compare against the latched, clamped period.
  - No arithmetic on duty beyond the clamp.
  - Pointer width is clog2(NREQ).

## Timing
- `req` rises in IDLE at edge N:
  - ARB at N+1.
  - `grant` and config valid at N+2.
  - `pwm_rst` falls at N+2+LOAD_CYCLES.
- Run length: exactly HOLD_PERIODS × period cycles with `pwm_rst` = 0.
- `done`/`abort` are high for exactly the RELEASE cycle.
- Back-to-back owners: at least 1 (RELEASE) + 1 (ARB) + LOAD_CYCLES cycles with `pwm_rst` = 1 between runs.
- `rst` asserted mid-RUN:
  - All outputs go to reset values immediately (asynchronous), with no `done`/`abort`.
  - Release is synchronous; first ARB occurs one cycle after `rst` = 1 is sampled with `req` set.

## Configuration
- `PWM_ARB_FIXED_PRIO_EN`:
  - Defined: ARB picks the lowest-index set `req` bit and the RR pointer is unused (held at 0).
  - Undefined: round-robin as described above.
  - All other behaviour is identical in both builds.

## Structure
- Package `pwm_arb_pkg`:
  - State typedef/encodings (IDLE=0, ARB=1, LOAD=2, RUN=3, RELEASE=4).
  - Constants DUTY_MAX=100 and PERIOD_MIN=2.
- Sub-module `pwm_rr_pick`: combinational round-robin picker.
  - Inputs: `req`, pointer. Outputs: one-hot winner, index, `any`.
  - The fixed-priority macro is handled inside it.

## Test plan
- Reset hold: `rst`=0 with `req`=4'b1111 → `grant`=0, `pwm_rst`=1, `busy`=0 throughout.
- Single requester: `req`=4'b0010, period=10, duty=30 → `grant`=4'b0010 two cycles after `req`; `pwm_rst`=0 for exactly 40 cycles; one `done` pulse; `dutyCycle`=30.
- Round-robin: `req`=4'b1111 held → grants 0001, 0010, 0100, 1000, 0001 in order. With `PWM_ARB_FIXED_PRIO_EN` defined → 0001 every time.
- Clamp: period=0, duty=150 → `period`=2, `dutyCycle`=100, run length 8 cycles.
- Early drop: owner 2 drops `req` at RUN cycle 5 → `abort` pulse one cycle later, `grant`=0, `pwm_rst`=1, no `done`; requester 3 granted next.
- Async reset mid-RUN: `rst`=0 between edges → `pwm_rst`=1 and `grant`=0 before the next edge; the next run after release starts from IDLE with pointer 0.

Source files
------------

// File: rtl/pwm_arb_pkg.sv
// Shared types and constants for the pwm_arbiter slice: FSM encodings and config clamp limits.
package pwm_arb_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArb     = 3'd1,
    StLoad    = 3'd2,
    StRun     = 3'd3,
    StRelease = 3'd4
  } arbState_e;

  localparam logic [7:0]  DUTY_MAX   = 8'd100;
  localparam logic [15:0] PERIOD_MIN = 16'd2;

endpackage

// File: rtl/pwm_arbiter_if.sv
// Requester-side bundle of pwm_arbiter: requests and per-requester configuration in,
// grant and shared-generator controls out.
interface pwm_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] cfg_period;
  logic [NREQ*8-1:0]  cfg_duty;
  logic [NREQ-1:0]    cfg_mode;
  logic [NREQ-1:0]    cfg_type;

  logic [NREQ-1:0]    grant;
  logic [15:0]        period;
  logic [7:0]         dutyCycle;
  logic               modeBurst;
  logic               typeBurst;
  logic               pwm_rst;
  logic               busy;
  logic               done;
  logic               abort;

  modport master (
    output req, cfg_period, cfg_duty, cfg_mode, cfg_type,
    input  grant, period, dutyCycle, modeBurst, typeBurst, pwm_rst, busy, done, abort
  );

  modport slave (
    input  req, cfg_period, cfg_duty, cfg_mode, cfg_type,
    output grant, period, dutyCycle, modeBurst, typeBurst, pwm_rst, busy, done, abort
  );
endinterface

// File: rtl/pwm_rr_pick.sv
// Combinational requester picker: round-robin from ptr, or lowest index when
// PWM_ARB_FIXED_PRIO_EN is defined (ptr then ignored).
module pwm_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         winner,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);
  localparam int unsigned PW = $clog2(NREQ);

`ifdef PWM_ARB_FIXED_PRIO_EN
  logic unusedPtr;
  assign unusedPtr = ^ptr;

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
        idx       = PW'(i);
      end
    end
  end
`else
  always_comb begin : pick
    logic        found;
    int unsigned j;
    winner = '0;
    idx    = '0;
    any    = |req;
    found  = 1'b0;
    j      = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      j = (int'(ptr) + off) % NREQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        winner[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end
`endif

endmodule

// File: rtl/pwm_arbiter.sv
// Time-shares one pwm generator between NREQ requesters, holding each grant for HOLD_PERIODS
// periods. Define PWM_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module pwm_arbiter
  import pwm_arb_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned HOLD_PERIODS = 4,
  parameter int unsigned LOAD_CYCLES  = 2
) (
  input logic          clk,
  input logic          rst,
  pwm_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned LW = (LOAD_CYCLES < 2) ? 1 : $clog2(LOAD_CYCLES);

  arbState_e       stateQ, stateD;
  logic [NREQ-1:0] grantQ, grantD;
  logic [15:0]     periodQ, periodD;
  logic [7:0]      dutyQ, dutyD;
  logic            modeQ, modeD, typeQ, typeD;
  logic [PW-1:0]   idxQ, idxD, rrPtrQ, rrPtrD;
  logic [15:0]     cycCntQ, cycCntD;
  logic [7:0]      perCntQ, perCntD;
  logic [LW-1:0]   loadCntQ, loadCntD;
  logic            abortedQ, abortedD;

  logic [NREQ-1:0] pickOneHot;
  logic [PW-1:0]   pickIdx;
  logic            pickAny;
  logic [15:0]     selPeriod;
  logic [7:0]      selDuty;
  logic            selMode, selType, ownerDrop;

  pwm_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .ptr    (rrPtrQ),
    .winner (pickOneHot),
    .idx    (pickIdx),
    .any    (pickAny)
  );

  always_comb begin
    selPeriod = '0;
    selDuty   = '0;
    selMode   = 1'b0;
    selType   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pickOneHot[i]) begin
        selPeriod = bus.cfg_period[i*16 +: 16];
        selDuty   = bus.cfg_duty[i*8 +: 8];
        selMode   = bus.cfg_mode[i];
        selType   = bus.cfg_type[i];
      end
    end
  end

  assign ownerDrop = ~|(bus.req & grantQ);

  always_comb begin
    stateD   = stateQ;
    grantD   = grantQ;
    periodD  = periodQ;
    dutyD    = dutyQ;
    modeD    = modeQ;
    typeD    = typeQ;
    idxD     = idxQ;
    rrPtrD   = rrPtrQ;
    cycCntD  = cycCntQ;
    perCntD  = perCntQ;
    loadCntD = loadCntQ;
    abortedD = abortedQ;
    unique case (stateQ)
      StIdle: if (pickAny) stateD = StArb;
      StArb: begin
        if (pickAny) begin
          grantD   = pickOneHot;
          idxD     = pickIdx;
          periodD  = (selPeriod < PERIOD_MIN) ? PERIOD_MIN : selPeriod;
          dutyD    = (selDuty > DUTY_MAX) ? DUTY_MAX : selDuty;
          modeD    = selMode;
          typeD    = selType;
          loadCntD = '0;
          stateD   = StLoad;
        end else begin
          stateD = StIdle;
        end
      end
      StLoad: begin
        if (ownerDrop) begin
          abortedD = 1'b1;
          grantD   = '0;
          stateD   = StRelease;
        end else if (loadCntQ == LW'(LOAD_CYCLES - 1)) begin
          cycCntD = '0;
          perCntD = '0;
          stateD  = StRun;
        end else begin
          loadCntD = loadCntQ + 1'b1;
        end
      end
      StRun: begin
        if (ownerDrop) begin
          abortedD = 1'b1;
          grantD   = '0;
          stateD   = StRelease;
        end else if (cycCntQ == periodQ - 16'd1) begin
          cycCntD = '0;
          perCntD = perCntQ + 8'd1;
          if (perCntQ + 8'd1 == 8'(HOLD_PERIODS)) begin
            abortedD = 1'b0;
            grantD   = '0;
            stateD   = StRelease;
          end
        end else begin
          cycCntD = cycCntQ + 16'd1;
        end
      end
      StRelease: begin
`ifdef PWM_ARB_FIXED_PRIO_EN
        rrPtrD = '0;
`else
        rrPtrD = (idxQ == PW'(NREQ - 1)) ? '0 : idxQ + 1'b1;
`endif
        stateD = pickAny ? StArb : StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= StIdle;
      grantQ   <= '0;
      periodQ  <= '0;
      dutyQ    <= '0;
      modeQ    <= 1'b0;
      typeQ    <= 1'b0;
      idxQ     <= '0;
      rrPtrQ   <= '0;
      cycCntQ  <= '0;
      perCntQ  <= '0;
      loadCntQ <= '0;
      abortedQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      grantQ   <= grantD;
      periodQ  <= periodD;
      dutyQ    <= dutyD;
      modeQ    <= modeD;
      typeQ    <= typeD;
      idxQ     <= idxD;
      rrPtrQ   <= rrPtrD;
      cycCntQ  <= cycCntD;
      perCntQ  <= perCntD;
      loadCntQ <= loadCntD;
      abortedQ <= abortedD;
    end
  end

  assign bus.grant     = grantQ;
  assign bus.period    = periodQ;
  assign bus.dutyCycle = dutyQ;
  assign bus.modeBurst = modeQ;
  assign bus.typeBurst = typeQ;
  assign bus.pwm_rst   = (stateQ != StRun);
  assign bus.busy      = (stateQ == StLoad) || (stateQ == StRun);
  assign bus.done      = (stateQ == StRelease) && !abortedQ;
  assign bus.abort     = (stateQ == StRelease) && abortedQ;

endmodule

// File: tb/tb_pwm_arbiter.sv
// Directed self-checking bench for pwm_arbiter (NREQ=4, HOLD_PERIODS=4, LOAD_CYCLES=2).
module tb_pwm_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  pwm_arbiter_if #(.NREQ(4)) bus ();

  pwm_arbiter #(
    .NREQ         (4),
    .HOLD_PERIODS (4),
    .LOAD_CYCLES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    bus.req = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++;
      if (bus.grant !== 4'b0000 || bus.pwm_rst !== 1'b1 || bus.busy !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold: grant=%b pwm_rst=%b busy=%b want 0000/1/0",
                 bus.grant, bus.pwm_rst, bus.busy);
      end
    end
    bus.req = '0;
    rst     = 1'b1;
    step();
  endtask

  task automatic test_single();
    int low = 0, dones = 0, aborts = 0;
    bus.cfg_period[16 +: 16] = 16'd10;
    bus.cfg_duty[8 +: 8]     = 8'd30;
    bus.req = 4'b0010;
    step();
    vecs++;
    if (bus.grant !== 4'b0000) begin
      errs++;
      $display("FAIL single_arb_grant: got %b want 0000", bus.grant);
    end
    step();
    vecs++;
    if (bus.grant !== 4'b0010 || bus.dutyCycle !== 8'd30 || bus.period !== 16'd10) begin
      errs++;
      $display("FAIL single_grant: grant=%b duty=%0d period=%0d want 0010/30/10",
               bus.grant, bus.dutyCycle, bus.period);
    end
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.pwm_rst === 1'b0) low++;
      if (bus.abort === 1'b1) aborts++;
      if (bus.done === 1'b1) begin
        dones++;
        bus.req = '0;
        vecs++;
        if (bus.grant !== 4'b0000 || bus.pwm_rst !== 1'b1) begin
          errs++;
          $display("FAIL single_release: grant=%b pwm_rst=%b want 0000/1",
                   bus.grant, bus.pwm_rst);
        end
      end
    end
    vecs++;
    if (low != 40 || dones != 1 || aborts != 0) begin
      errs++;
      $display("FAIL single_run: low=%0d done=%0d abort=%0d want 40/1/0", low, dones, aborts);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] got[5];
    logic [3:0] exp[5];
    logic [3:0] prev = '0;
    int n = 0;
`ifdef PWM_ARB_FIXED_PRIO_EN
    exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 300 && n < 5; i++) begin
      step();
      if (bus.grant !== 4'b0000 && prev === 4'b0000) begin
        got[n] = bus.grant;
        n++;
      end
      prev = bus.grant;
    end
    bus.req = '0;
    vecs++;
    if (n != 5) begin
      errs++;
      $display("FAIL rr_timeout: grants seen %0d want 5", n);
    end
    for (int k = 0; k < n; k++) begin
      vecs++;
      if (got[k] !== exp[k]) begin
        errs++;
        $display("FAIL rr_grant%0d: got %b want %b", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_clamp();
    int low = 0, dones = 0;
    do_reset();
    bus.cfg_period[0 +: 16] = 16'd0;
    bus.cfg_duty[0 +: 8]    = 8'd150;
    bus.cfg_mode[0]         = 1'b1;
    bus.cfg_type[0]         = 1'b0;
    bus.req = 4'b0001;
    step();
    step();
    vecs++;
    if (bus.period !== 16'd2 || bus.dutyCycle !== 8'd100 || bus.modeBurst !== 1'b1 ||
        bus.typeBurst !== 1'b0) begin
      errs++;
      $display("FAIL clamp_latch: period=%0d duty=%0d mode=%b type=%b want 2/100/1/0",
               bus.period, bus.dutyCycle, bus.modeBurst, bus.typeBurst);
    end
    // Mid-run config changes must not reach the latched outputs.
    bus.cfg_period[0 +: 16] = 16'd50;
    bus.cfg_duty[0 +: 8]    = 8'd10;
    bus.cfg_type[0]         = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.pwm_rst === 1'b0) low++;
      if (bus.done === 1'b1) begin
        dones++;
        bus.req = '0;
      end
    end
    vecs++;
    if (low != 8 || dones != 1) begin
      errs++;
      $display("FAIL clamp_run: low=%0d done=%0d want 8/1", low, dones);
    end
    vecs++;
    if (bus.period !== 16'd2 || bus.dutyCycle !== 8'd100 || bus.typeBurst !== 1'b0) begin
      errs++;
      $display("FAIL clamp_hold: period=%0d duty=%0d type=%b want 2/100/0",
               bus.period, bus.dutyCycle, bus.typeBurst);
    end
    bus.cfg_period[0 +: 16] = 16'd2;
    bus.cfg_type[0]         = 1'b0;
  endtask

  task automatic test_early_drop();
    logic seen = 1'b0;
    do_reset();
    bus.cfg_period[32 +: 16] = 16'd20;
    bus.req = 4'b0100;
    step();
    step();
    vecs++;
    if (bus.grant !== 4'b0100) begin
      errs++;
      $display("FAIL drop_grant: got %b want 0100", bus.grant);
    end
    bus.req = 4'b1100;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.pwm_rst === 1'b0) seen = 1'b1;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL drop_run_timeout: pwm_rst=%b want 0", bus.pwm_rst);
    end
    repeat (5) step();
    vecs++;
    if (bus.busy !== 1'b1 || bus.grant !== 4'b0100 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL drop_running: busy=%b grant=%b done=%b want 1/0100/0",
               bus.busy, bus.grant, bus.done);
    end
    bus.req = 4'b1000;
    step();
    vecs++;
    if (bus.abort !== 1'b1 || bus.done !== 1'b0 || bus.grant !== 4'b0000 ||
        bus.pwm_rst !== 1'b1) begin
      errs++;
      $display("FAIL drop_abort: abort=%b done=%b grant=%b pwm_rst=%b want 1/0/0000/1",
               bus.abort, bus.done, bus.grant, bus.pwm_rst);
    end
    step();
    vecs++;
    if (bus.abort !== 1'b0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL drop_pulse_width: abort=%b done=%b want 0/0", bus.abort, bus.done);
    end
    step();
    vecs++;
    if (bus.grant !== 4'b1000) begin
      errs++;
      $display("FAIL drop_next_owner: got %b want 1000", bus.grant);
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_async_reset();
    logic seen = 1'b0;
    do_reset();
    bus.req = 4'b0010;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.pwm_rst === 1'b0) seen = 1'b1;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL async_run_timeout: pwm_rst=%b want 0", bus.pwm_rst);
    end
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if (bus.pwm_rst !== 1'b1 || bus.grant !== 4'b0000 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.abort !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: pwm_rst=%b grant=%b busy=%b done=%b abort=%b want 1/0000/0/0/0",
               bus.pwm_rst, bus.grant, bus.busy, bus.done, bus.abort);
    end
    bus.req = 4'b1010;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    vecs++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL async_arb: grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
    step();
    vecs++;
    if (bus.grant !== 4'b0010) begin
      errs++;
      $display("FAIL async_ptr0: got %b want 0010", bus.grant);
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      bus.cfg_period[i*16 +: 16] = 16'd2;
      bus.cfg_duty[i*8 +: 8]     = 8'd50;
    end
    bus.cfg_mode = '0;
    bus.cfg_type = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_clamp();
    test_early_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
